desc_load_ctrl: RTL

DESC_LOAD_CTRL -- requirements
Module: desc_load_ctrl

---
 rtl/desc_load_ctrl_if.sv | 14 +
 rtl/desc_load_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/desc_load_ctrl_if.sv
// Dword memory port between the descriptor loader (master) and the memory system (slave).
interface desc_load_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/desc_load_ctrl.sv
// Segment descriptor loader: fetches an 8-byte GDT/LDT entry over a dword port into the global registers.
// Optional macro DESC_LOAD_ACCESSED_EN adds write-back of the descriptor accessed bit (bit 40).
module desc_load_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] req_selector,
    input  logic        req_target,
    output logic        req_ready,
    input  logic [31:0] gdtr_base,
    input  logic [15:0] gdtr_limit,
    input  logic [31:0] ldtr_base,
    input  logic [31:0] ldtr_limit,
    desc_load_ctrl_if.master mem,
    output logic        glob_descriptor_set,
    output logic [63:0] glob_descriptor_value,
    output logic        glob_descriptor_2_set,
    output logic [63:0] glob_descriptor_2_value,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_kind,
    output logic [15:0] fault_ec
);
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_ACC, FINISH, FAULT} state_t;

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] K_NULL    = 2'd0;
    localparam logic [1:0] K_LIMIT   = 2'd1;
    localparam logic [1:0] K_TIMEOUT = 2'd2;

    state_t      state;
    logic        tgt_q;
    logic [31:0] addr_hi_q;
    logic [31:0] lo_q;
    logic [7:0]  tcnt;

    logic [31:0] tbl_base;
    logic [31:0] tbl_limit;
    logic [31:0] offs;
    logic [31:0] sel_top;
    logic [31:0] hi_fin;
    logic        is_null;
    logic        over_limit;
    logic        fin_now;

`ifdef DESC_LOAD_ACCESSED_EN
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] hi_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_wdata = wdata_q;
    assign hi_fin        = (state == WR_ACC) ? hi_q : mem.mem_rdata;
    // Finish straight from RD_HI only when the accessed bit is already set.
    assign fin_now = mem.mem_ack &&
                     (((state == RD_HI) && mem.mem_rdata[8]) || (state == WR_ACC));
`else
    assign mem.mem_we    = 1'b0;
    assign mem.mem_wdata = 32'h0;
    assign hi_fin        = mem.mem_rdata;
    assign fin_now       = mem.mem_ack && (state == RD_HI);
`endif

    always_comb begin
        tbl_base   = req_selector[2] ? ldtr_base  : gdtr_base;
        tbl_limit  = req_selector[2] ? ldtr_limit : {16'h0, gdtr_limit};
        offs       = {16'h0, req_selector[15:3], 3'b000};
        sel_top    = {16'h0, req_selector[15:3], 3'b111};
        is_null    = !req_selector[2] && (req_selector[15:3] == 13'd0);
        over_limit = sel_top > tbl_limit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= IDLE;
            req_ready               <= 1'b1;
            mem.mem_req             <= 1'b0;
            mem.mem_addr            <= 32'h0;
            tgt_q                   <= 1'b0;
            addr_hi_q               <= 32'h0;
            lo_q                    <= 32'h0;
            tcnt                    <= 8'h0;
            glob_descriptor_set     <= 1'b0;
            glob_descriptor_2_set   <= 1'b0;
            glob_descriptor_value   <= 64'h0;
            glob_descriptor_2_value <= 64'h0;
            done                    <= 1'b0;
            fault                   <= 1'b0;
            fault_kind              <= K_NULL;
            fault_ec                <= 16'h0;
`ifdef DESC_LOAD_ACCESSED_EN
            we_q                    <= 1'b0;
            wdata_q                 <= 32'h0;
            hi_q                    <= 32'h0;
`endif
        end else begin
            done                  <= 1'b0;
            fault                 <= 1'b0;
            glob_descriptor_set   <= 1'b0;
            glob_descriptor_2_set <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    tgt_q     <= req_target;
                    addr_hi_q <= tbl_base + offs + 32'd4;
                    fault_ec  <= {req_selector[15:2], 2'b00};
                    req_ready <= 1'b0;
                    if (is_null) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_kind <= K_NULL;
                    end else if (over_limit) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_kind <= K_LIMIT;
                    end else begin
                        state        <= RD_LO;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= tbl_base + offs;
                        tcnt         <= 8'h0;
                    end
                end
                RD_LO, RD_HI, WR_ACC: begin
                    if (mem.mem_ack) begin
                        if (state == RD_LO) begin
                            lo_q         <= mem.mem_rdata;
                            state        <= RD_HI;
                            mem.mem_addr <= addr_hi_q;
                            tcnt         <= 8'h0;
                        end
`ifdef DESC_LOAD_ACCESSED_EN
                        else if ((state == RD_HI) && !mem.mem_rdata[8]) begin
                            state   <= WR_ACC;
                            we_q    <= 1'b1;
                            wdata_q <= mem.mem_rdata | 32'h100;
                            hi_q    <= mem.mem_rdata | 32'h100;
                            tcnt    <= 8'h0;
                        end
`endif
                    end else if (tcnt == TO_LAST) begin
                        state       <= FAULT;
                        mem.mem_req <= 1'b0;
                        fault       <= 1'b1;
                        fault_kind  <= K_TIMEOUT;
`ifdef DESC_LOAD_ACCESSED_EN
                        we_q        <= 1'b0;
`endif
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
            // Completion overrides the per-state updates above.
            if (fin_now) begin
                state       <= FINISH;
                mem.mem_req <= 1'b0;
                done        <= 1'b1;
`ifdef DESC_LOAD_ACCESSED_EN
                we_q        <= 1'b0;
`endif
                if (tgt_q) begin
                    glob_descriptor_2_set   <= 1'b1;
                    glob_descriptor_2_value <= {hi_fin, lo_q};
                end else begin
                    glob_descriptor_set     <= 1'b1;
                    glob_descriptor_value   <= {hi_fin, lo_q};
                end
            end
        end
    end
endmodule
